// File: rtl/sha2_round_engine.sv
// SHA-256/SHA-224 compression engine: one 512-bit block in, one 256-bit chaining digest out.
// Latency: 64/ROUNDS_PER_CYCLE + 1 cycles from block acceptance to out_valid_o.
// Backpressure: in_ready_o is high only in IDLE; the digest holds in DONE until out_ready_i.
//
// Ports:
//   clk_i, rst_ni     clock (rising edge) and asynchronous active-low reset
//   clr_ni            synchronous active-low clear; aborts and restores the SHA-256 IV
//   in_valid_i/in_ready_o, block_i, first_i, sha224_i   block input handshake
//   busy_o            compression in progress (ROUND or FINAL)
//   out_valid_o/out_ready_i, digest_o                   digest output handshake
module sha2_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [511:0] block_i,
  input  logic         first_i,
  input  logic         sha224_i,
  output logic         busy_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [255:0] digest_o
);

  localparam int RPC = ROUNDS_PER_CYCLE;

  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter value during the last ROUND cycle.
  localparam logic [5:0] LAST_CNT = 6'(64 - RPC);

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [0:15][31:0] w_q, w_d;      // w_q[0] is W[t] for the next round
  logic [0:7][31:0]  wv_q, wv_d;    // working variables a..h
  logic [0:7][31:0]  h_q, h_d;      // chaining value H0..H7
  logic              mode_q, mode_d; // 1 = SHA-224
  logic [0:7][31:0]  dig_q, dig_d;

  logic [0:7][31:0]  wv_rnd;
  logic [0:15][31:0] w_nxt;

  // ROUNDS_PER_CYCLE chained rounds. The schedule window is extended by RPC
  // words so each round finds its W directly; the extra words become the
  // tail of the shifted window.
  always_comb begin : p_rounds
    logic [0:15+RPC][31:0] ws;
    logic [0:7][31:0]      v;
    logic [31:0]           t1, t2;
    logic [5:0]            kidx;
    ws     = '0;
    v      = wv_q;
    t1     = '0;
    t2     = '0;
    kidx   = '0;
    w_nxt  = '0;
    ws[0:15] = w_q;
    for (int j = 0; j < RPC; j++) begin
      ws[16+j] = ssig1(ws[14+j]) + ws[9+j] + ssig0(ws[1+j]) + ws[j];
    end
    for (int r = 0; r < RPC; r++) begin
      kidx = cnt_q + 6'(r);
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_ROM[kidx] + ws[r];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v  = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
    end
    wv_rnd = v;
    for (int i = 0; i < 16; i++) begin
      w_nxt[i] = ws[i+RPC];
    end
  end

  // Datapath next-state.
  always_comb begin
    cnt_d  = cnt_q;
    w_d    = w_q;
    wv_d   = wv_q;
    h_d    = h_q;
    mode_d = mode_q;
    dig_d  = dig_q;
    if (!clr_ni) begin
      cnt_d  = '0;
      h_d    = IV256;
      mode_d = 1'b0;
      dig_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            w_d   = block_i;
            cnt_d = '0;
            if (first_i) begin
              mode_d = sha224_i;
              h_d    = sha224_i ? IV224 : IV256;
              wv_d   = h_d;
            end else begin
              wv_d = h_q;
            end
          end
        end
        S_ROUND: begin
          wv_d  = wv_rnd;
          w_d   = w_nxt;
          cnt_d = cnt_q + 6'(RPC);
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            h_d[i] = h_q[i] + wv_q[i];
          end
          dig_d = h_d;
        end
        default: ;
      endcase
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    if (!clr_ni) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid_i) state_d = S_ROUND;
        S_ROUND: if (cnt_q == LAST_CNT) state_d = S_FINAL;
        S_FINAL: state_d = S_DONE;
        S_DONE:  if (out_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE);
    busy_o      = (state_q == S_ROUND) || (state_q == S_FINAL);
    out_valid_o = (state_q == S_DONE);
  end

  // The stored digest is full width; truncation to 224 bits happens here.
  assign digest_o = mode_q ? {dig_q[0:6], 32'h0} : dig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      w_q    <= '0;
      wv_q   <= '0;
      h_q    <= IV256;
      mode_q <= 1'b0;
      dig_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      wv_q   <= wv_d;
      h_q    <= h_d;
      mode_q <= mode_d;
      dig_q  <= dig_d;
    end
  end

endmodule

// File: tb/tb_sha2_round_engine.sv
// Testbench for sha2_round_engine: directed known-answer vectors plus random blocks
// checked against a one-round-at-a-time SHA-256 model through a digest scoreboard.
module tb_sha2_round_engine;

  localparam int RPC  = 1;
  localparam int NCYC = 64 / RPC;
  localparam int LAT  = NCYC + 1;

  logic         clk = 1'b0;
  logic         rst_n, clr_n;
  logic         in_valid_i, in_ready_o, first_i, sha224_i;
  logic [511:0] block_i;
  logic         busy_o, out_valid_o, out_ready_i;
  logic [255:0] digest_o;

  always #5 clk = ~clk;

  sha2_round_engine #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_ni(clr_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .block_i(block_i),
    .first_i(first_i), .sha224_i(sha224_i), .busy_o(busy_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .digest_o(digest_o)
  );

  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] D_CHAIN  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int           n_cmp = 0;
  int           n_err = 0;
  logic [255:0] exp_q[$];
  logic [255:0] mdl_h;
  bit           mdl_224;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-entry schedule, one round per loop step.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  s [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Monitor: every digest handed over is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_digest: got %h with nothing expected", digest_o);
      end else begin
        chk("digest", digest_o, exp_q.pop_front());
      end
    end
  end

  // Offers a block and returns just after the edge that accepted it.
  task automatic accept(input logic [511:0] blk, input bit first, input bit s224);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) tmo("accept");
    block_i    = blk;
    first_i    = first;
    sha224_i   = s224;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [511:0] blk, input bit first, input bit s224,
                       input bit push, input bit use_lit, input logic [255:0] lit);
    if (first) begin
      mdl_224 = s224;
      mdl_h   = s224 ? IV224 : IV256;
    end
    mdl_h = ref_compress(mdl_h, blk);
    accept(blk, first, s224);
    if (push) exp_q.push_back(use_lit ? lit : (mdl_224 ? {mdl_h[255:32], 32'h0} : mdl_h));
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && n < 3000) begin
      @(posedge clk);
      #1;
      out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    out_ready_i = 1'b1;
    if (exp_q.size() != 0 || !in_ready_o) tmo("wait_idle");
  endtask

  task automatic check_latency(input string nm);
    int n;
    n = 0;
    while (!out_valid_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 256'(n), 256'(LAT));
  endtask

  task automatic model_reset();
    mdl_h   = IV256;
    mdl_224 = 1'b0;
  endtask

  initial begin
    logic [511:0] rb;
    int           n;
    rst_n = 1'b0; clr_n = 1'b1; in_valid_i = 1'b0; block_i = '0;
    first_i = 1'b0; sha224_i = 1'b0; out_ready_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(in_ready_o), 256'(1));
    chk("rst_busy", 256'(busy_o), 256'(0));
    chk("rst_out_valid", 256'(out_valid_o), 256'(0));
    chk("rst_digest", digest_o, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SHA-256 and SHA-224 "abc".
    issue(ABC, 1'b1, 1'b0, 1'b1, 1'b1, D_ABC256);
    check_latency("latency_abc256");
    wait_idle(1'b0);
    issue(ABC, 1'b1, 1'b1, 1'b1, 1'b1, D_ABC224);
    wait_idle(1'b0);

    // Two-block chaining; sha224_i on a continuation block must be ignored.
    issue(M1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    issue(M2, 1'b0, 1'b0, 1'b1, 1'b1, D_CHAIN);
    wait_idle(1'b0);
    issue(M1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    issue(M2, 1'b0, 1'b1, 1'b1, 1'b1, D_CHAIN);
    wait_idle(1'b0);

    // Backpressure: digest and handshakes hold; a block offered meanwhile is dropped.
    out_ready_i = 1'b0;
    issue(EMPTY, 1'b1, 1'b0, 1'b1, 1'b1, D_EMPTY);
    n = 0;
    while (!out_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) tmo("bp_wait_valid");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_digest_hold", digest_o, D_EMPTY);
      chk("bp_in_ready_low", 256'(in_ready_o), 256'(0));
      if (c == 5) begin
        for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom();
        block_i = rb; first_i = 1'b1; sha224_i = 1'b1; in_valid_i = 1'b1;
      end
      if (c == 12) in_valid_i = 1'b0;
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    wait_idle(1'b0);
    repeat (4) @(negedge clk);
    chk("bp_not_consumed_busy", 256'(busy_o), 256'(0));
    chk("bp_not_consumed_ready", 256'(in_ready_o), 256'(1));

    // Abort with clear at round 30 of a SHA-224 block.
    for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom();
    issue(rb, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (30 / RPC) @(posedge clk);
    #1;
    chk("abort_busy_before", 256'(busy_o), 256'(1));
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    model_reset();
    chk("abort_in_ready", 256'(in_ready_o), 256'(1));
    chk("abort_out_valid", 256'(out_valid_o), 256'(0));
    chk("abort_busy", 256'(busy_o), 256'(0));
    chk("abort_digest", digest_o, 256'h0);
    issue(ABC, 1'b0, 1'b1, 1'b1, 1'b1, D_ABC256);
    wait_idle(1'b0);

    // Asynchronous reset during FINAL.
    issue(ABC, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (NCYC) @(posedge clk);
    #1;
    chk("areset_in_final", 256'(busy_o), 256'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_out_valid", 256'(out_valid_o), 256'(0));
    chk("areset_digest", digest_o, 256'h0);
    chk("areset_in_ready", 256'(in_ready_o), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue(ABC, 1'b1, 1'b0, 1'b1, 1'b1, D_ABC256);
    check_latency("latency_after_reset");
    wait_idle(1'b0);

    // Random blocks, modes and chaining with random output backpressure.
    for (int i = 0; i < 12; i++) begin
      for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom();
      issue(rb, (i == 0) || ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0);
      wait_idle(1'b1);
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
